// File: rtl/sccb_pkg.sv
// +------------------------------------------------------------------+
// | sccb_pkg                                                          |
// | Shared SCCB slave types, constants and ID-match helper.           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package sccb_pkg;

  localparam logic [7:0] SCCB_ID_OV7670 = 8'h42;
  localparam int         BIT_CNT_W      = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ACK_ID,
    ST_SUB,
    ST_ACK_SUB,
    ST_WDATA,
    ST_ACK_WD,
    ST_RDATA,
    ST_MACK,
    ST_IGNORE
  } sccb_state_e;

  // Either the write ID or its read twin (LSB set) addresses the block.
  function automatic logic id_match(input logic [7:0] id_byte, input logic [7:0] dev_id);
    return (id_byte == dev_id) || (id_byte == (dev_id | 8'h01));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sccb_edge_sync.sv
// +------------------------------------------------------------------+
// | sccb_edge_sync                                                    |
// | SCL/SDA synchronizers with SCL edge and START/STOP detection.     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module sccb_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // One extra flop beyond the synchronizer holds the previous sampled level.
  logic [SYNC_STAGES:0] scl_q;
  logic [SYNC_STAGES:0] sda_q;

  logic w_scl_now;
  logic w_scl_prev;
  logic w_sda_now;
  logic w_sda_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-1:0], scl_i};
      sda_q <= {sda_q[SYNC_STAGES-1:0], sda_i};
    end
  end

  assign w_scl_now  = scl_q[SYNC_STAGES-1];
  assign w_scl_prev = scl_q[SYNC_STAGES];
  assign w_sda_now  = sda_q[SYNC_STAGES-1];
  assign w_sda_prev = sda_q[SYNC_STAGES];

  assign sda_o      = w_sda_now;
  assign scl_rise_o = w_scl_now & ~w_scl_prev;
  assign scl_fall_o = ~w_scl_now & w_scl_prev;
  assign start_o    = w_scl_now & w_scl_prev & w_sda_prev & ~w_sda_now;
  assign stop_o     = w_scl_now & w_scl_prev & ~w_sda_prev & w_sda_now;

endmodule

`default_nettype wire

// File: rtl/sccb_slave.sv
// +------------------------------------------------------------------+
// | sccb_slave                                                        |
// | SCCB (OV7670-style) slave: 3-phase write, 2-phase read protocol.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = SCCB_ID_OV7670,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sccb_scl,
  inout  wire        sccb_sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  sccb_state_e          state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 oe_q, oe_d;
  logic                 we_q, we_d;
  logic                 nack_q, nack_d;

  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;

  sccb_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (sccb_scl),
    .sda_i      (sccb_sda),
    .sda_o      (w_sda),
    .scl_rise_o (w_scl_rise),
    .scl_fall_o (w_scl_fall),
    .start_o    (w_start),
    .stop_o     (w_stop)
  );

  assign w_byte = {shift_q[6:0], w_sda};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    we_d    = 1'b0;
    nack_d  = nack_q;

    if (w_start) begin
      state_d = ST_ID;
      cnt_d   = '0;
      oe_d    = 1'b0;
      nack_d  = 1'b0;
    end else if (w_stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      nack_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ID, ST_SUB, ST_WDATA: begin
          if (w_scl_rise) begin
            shift_d = w_byte;
            cnt_d   = cnt_q + BIT_CNT_W'(1);
            if (cnt_q == BIT_CNT_W'(7)) begin
              cnt_d = '0;
              if (state_q == ST_ID) begin
                if (id_match(w_byte, DEV_ID)) begin
                  state_d = ST_ACK_ID;
                end else begin
                  state_d = ST_IGNORE;
                  nack_d  = 1'b1;
                end
              end else if (state_q == ST_SUB) begin
                addr_d  = w_byte;
                state_d = ST_ACK_SUB;
              end else begin
                wdata_d = w_byte;
                we_d    = 1'b1;
                state_d = ST_ACK_WD;
              end
            end
          end
        end

        // First SCL fall pulls SDA low for the ACK bit, the second one releases it.
        ST_ACK_ID, ST_ACK_SUB, ST_ACK_WD: begin
          if (w_scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = '0;
              if (state_q == ST_ACK_ID) begin
                if (shift_q[0]) begin
                  state_d = ST_RDATA;
                  shift_d = reg_rdata;
                  oe_d    = ~reg_rdata[7];
                end else begin
                  state_d = ST_SUB;
                end
              end else if (state_q == ST_ACK_SUB) begin
                state_d = ST_WDATA;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_RDATA: begin
          if (w_scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + BIT_CNT_W'(1);
            if (cnt_q == BIT_CNT_W'(7)) begin
              cnt_d   = '0;
              state_d = ST_MACK;
            end
          end else if (w_scl_fall) begin
            oe_d = ~shift_q[7];
          end
        end

        ST_MACK: begin
          if (w_scl_fall) begin
            oe_d = 1'b0;
          end else if (w_scl_rise) begin
            state_d = ST_IGNORE;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign sccb_sda  = oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign busy      = (state_q != ST_IDLE) && !((state_q == ST_IGNORE) && nack_q);

endmodule

`default_nettype wire
